// File: rtl/adc_trigger_pkg.sv
// adc_trigger_seq shared types: mode and FSM encodings,
// plus the minimum usable trigger period.
package adc_trigger_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      CONT  = 2'd1,
      BURST = 2'd2,
      RSVD  = 2'd3
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/adc_trigger_sync.sv
// Two-flop synchronizer plus registered rising-edge detect
// for the external sync input (ADC_TRIGGER_EXT_SYNC_EN builds).
module adc_trigger_sync
   import adc_trigger_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic pulse
);

   logic s1;
   logic s2;
   logic s3;

   // metastability stages, edge history and one-cycle edge pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         s3    <= 1'b0;
         pulse <= 1'b0;
      end else begin
         s1    <= async_in;
         s2    <= s1;
         s3    <= s2;
         pulse <= s2 & ~s3;
      end
   end

endmodule

// File: rtl/adc_trigger_seq.sv
// ADC trigger sequencer: continuous or burst trigger pulse train.
// Optional ext_sync start input when ADC_TRIGGER_EXT_SYNC_EN is defined.
module adc_trigger_seq
   import adc_trigger_pkg::*;
#(
   parameter int DIV_WIDTH = 32,
   parameter int CNT_WIDTH = 16,
   parameter int PULSE_LEN = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DIV_WIDTH-1:0] divider,
   input  logic [1:0]           mode,
   input  logic [CNT_WIDTH-1:0] burst_len,
   input  logic                 start,
   input  logic                 stop,
   output logic                 trigger,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] trig_count
`ifdef ADC_TRIGGER_EXT_SYNC_EN
   ,
   input  logic                 ext_sync
`endif
);

   state_e               state;
   state_e               state_nx;
   mode_e                mode_q;
   logic [DIV_WIDTH-1:0] div_q;
   logic [CNT_WIDTH-1:0] len_q;
   logic [DIV_WIDTH-1:0] phase;
   logic [DIV_WIDTH-1:0] phase_nx;
   logic [DIV_WIDTH-1:0] period;
   logic [DIV_WIDTH-1:0] p_m1;
   logic [DIV_WIDTH-1:0] hi;
   logic [DIV_WIDTH-1:0] ph_wrap;
   logic [CNT_WIDTH-1:0] cnt_nx;
   logic                 trig_nx;
   logic                 done_nx;
   logic                 go;
   logic                 accept;
   logic                 zero_burst;
   logic                 burst_end;

`ifdef ADC_TRIGGER_EXT_SYNC_EN
   logic sync_pulse;

   adc_trigger_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (ext_sync),
      .pulse    (sync_pulse)
   );

   assign go = start | sync_pulse;
`else
   assign go = start;
`endif

   assign accept = (state == IDLE) & go & ~stop &
                   ((mode == CONT) | (mode == BURST));
   assign zero_burst = accept & (mode == BURST) &
                       (burst_len == '0);

   assign period = (div_q < DIV_WIDTH'(MIN_PERIOD)) ?
                   DIV_WIDTH'(MIN_PERIOD) : div_q;
   assign p_m1 = period - DIV_WIDTH'(1);
   assign hi = (DIV_WIDTH'(PULSE_LEN) < p_m1) ?
               DIV_WIDTH'(PULSE_LEN) : p_m1;
   assign ph_wrap = (phase == p_m1) ?
                    '0 : phase + DIV_WIDTH'(1);

   // leave one cycle early so done lands on the last period cycle
   assign burst_end = (state == RUN) & (mode_q == BURST) &
                      (trig_count == len_q) &
                      (phase == period - DIV_WIDTH'(2));

   assign busy = (state == RUN);

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept && !zero_burst) state_nx = RUN;
         RUN:  if (stop || burst_end)     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // next values of the registered outputs and phase counter
   always_comb begin
      phase_nx = '0;
      trig_nx  = 1'b0;
      done_nx  = 1'b0;
      cnt_nx   = trig_count;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (zero_burst) begin
                  cnt_nx  = '0;
                  done_nx = 1'b1;
               end else begin
                  cnt_nx  = CNT_WIDTH'(1);
                  trig_nx = 1'b1;
               end
            end
         end
         RUN: begin
            if (stop) begin
               trig_nx = 1'b0;
            end else if (burst_end) begin
               done_nx = 1'b1;
            end else begin
               phase_nx = ph_wrap;
               trig_nx  = (ph_wrap < hi);
               if (ph_wrap == '0)
                  cnt_nx = trig_count + CNT_WIDTH'(1);
            end
         end
         default: ;
      endcase
   end

   // output, phase and latched configuration registers
   always_ff @(posedge clk) begin
      if (reset) begin
         phase      <= '0;
         trigger    <= 1'b0;
         done       <= 1'b0;
         trig_count <= '0;
         div_q      <= '0;
         mode_q     <= OFF;
         len_q      <= '0;
      end else begin
         phase      <= phase_nx;
         trigger    <= trig_nx;
         done       <= done_nx;
         trig_count <= cnt_nx;
         if (accept) begin
            div_q  <= divider;
            mode_q <= mode_e'(mode);
            len_q  <= burst_len;
         end
      end
   end

endmodule

// File: tb/tb_adc_trigger_seq.sv
// Testbench for adc_trigger_seq: vector table, directed corners,
// random stimulus against a period-arithmetic reference model.
module tb_adc_trigger_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] divider = '0;
   logic [1:0]  mode = '0;
   logic [15:0] burst_len = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        trig0, busy0, done0;
   logic        trig1, busy1, done1;
   logic [15:0] cnt0, cnt1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   adc_trigger_seq #(.DIV_WIDTH(32), .CNT_WIDTH(16), .PULSE_LEN(1)) u0 (
      .clk(clk), .reset(reset), .divider(divider), .mode(mode),
      .burst_len(burst_len), .start(start), .stop(stop),
      .trigger(trig0), .busy(busy0), .done(done0), .trig_count(cnt0)
`ifdef ADC_TRIGGER_EXT_SYNC_EN
      , .ext_sync(1'b0)
`endif
   );

   adc_trigger_seq #(.DIV_WIDTH(32), .CNT_WIDTH(16), .PULSE_LEN(5)) u1 (
      .clk(clk), .reset(reset), .divider(divider), .mode(mode),
      .burst_len(burst_len), .start(start), .stop(stop),
      .trigger(trig1), .busy(busy1), .done(done1), .trig_count(cnt1)
`ifdef ADC_TRIGGER_EXT_SYNC_EN
      , .ext_sync(1'b0)
`endif
   );

   // reference model: sequence time since start plus latched config
   bit     m_run = 0;
   longint m_t = 0;
   longint m_div = 0;
   longint m_len = 0;
   longint m_hold = 0;
   int     m_mode = 0;

   function automatic void mexp(input longint pl, output bit tr,
                                output bit bu, output bit dn,
                                output longint cn);
      longint p, hi, k;
      tr = 0; bu = 0; dn = 0; cn = m_hold;
      if (!m_run) return;
      p  = (m_div < 2) ? 2 : m_div;
      hi = (pl < p - 1) ? pl : p - 1;
      k  = m_t - 1;
      if (m_mode == 1) begin
         tr = (k % p) < hi; bu = 1; cn = (k / p + 1) % 65536;
      end else if (m_len == 0) begin
         dn = (m_t == 1); cn = 0;
      end else if (m_t < m_len * p) begin
         tr = (k % p) < hi; bu = 1; cn = k / p + 1;
      end else begin
         dn = 1; cn = m_len;
      end
   endfunction

   function automatic void mupd(bit r, bit s, bit sp, int md,
                                longint dv, longint bl);
      bit tr, bu, dn;
      longint cn;
      mexp(1, tr, bu, dn, cn);
      if (r) begin
         m_run = 0; m_hold = 0;
      end else if (bu) begin
         if (sp) begin m_run = 0; m_hold = cn; end
         else m_t++;
      end else if (s && !sp && (md == 1 || md == 2)) begin
         m_run = 1; m_t = 1; m_div = dv; m_mode = md;
         m_len = bl; m_hold = 0;
      end else begin
         m_run = 0; m_hold = cn;
      end
   endfunction

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0d expected %0d",
                  name, cyc, act, exp);
      end
   endtask

   task automatic cmp_model();
      bit tr, bu, dn;
      longint cn;
      mexp(1, tr, bu, dn, cn);
      chk("m0_trig", trig0, tr); chk("m0_busy", busy0, bu);
      chk("m0_done", done0, dn); chk("m0_cnt", cnt0, cn);
      mexp(5, tr, bu, dn, cn);
      chk("m1_trig", trig1, tr); chk("m1_busy", busy1, bu);
      chk("m1_done", done1, dn); chk("m1_cnt", cnt1, cn);
   endtask

   task automatic step(bit r, bit s, bit sp, int md,
                       longint dv, longint bl);
      reset = r; start = s; stop = sp;
      mode = 2'(md); divider = 32'(dv); burst_len = 16'(bl);
      @(posedge clk);
      mupd(r, s, sp, md, dv, bl);
      #1;
      cyc++;
      cmp_model();
   endtask

   typedef struct {
      bit r, s, sp;
      int md, dv, bl;
      bit et, eb, ed;
      int ec;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // burst div 4 len 3, with noise on config and a start mid-run
      tbl.push_back('{1,0,0, 0,0,0,  0,0,0,0});
      tbl.push_back('{0,1,0, 2,4,3,  1,1,0,1});
      tbl.push_back('{0,0,0, 1,9,7,  0,1,0,1});
      tbl.push_back('{0,0,0, 2,4,3,  0,1,0,1});
      tbl.push_back('{0,0,0, 2,4,3,  0,1,0,1});
      tbl.push_back('{0,0,0, 2,4,3,  1,1,0,2});
      tbl.push_back('{0,1,0, 1,2,1,  0,1,0,2});
      tbl.push_back('{0,0,0, 2,4,3,  0,1,0,2});
      tbl.push_back('{0,0,0, 2,4,3,  0,1,0,2});
      tbl.push_back('{0,0,0, 2,4,3,  1,1,0,3});
      tbl.push_back('{0,0,0, 2,4,3,  0,1,0,3});
      tbl.push_back('{0,0,0, 2,4,3,  0,1,0,3});
      tbl.push_back('{0,0,0, 2,4,3,  0,0,1,3});
      tbl.push_back('{0,0,0, 2,4,3,  0,0,0,3});
      // continuous div 0 -> period 2, then stop / ignored starts
      tbl.push_back('{0,1,0, 1,0,0,  1,1,0,1});
      tbl.push_back('{0,0,0, 1,0,0,  0,1,0,1});
      tbl.push_back('{0,0,0, 1,0,0,  1,1,0,2});
      tbl.push_back('{0,0,0, 1,0,0,  0,1,0,2});
      tbl.push_back('{0,0,1, 1,0,0,  0,0,0,2});
      tbl.push_back('{0,1,1, 1,5,0,  0,0,0,2});
      tbl.push_back('{0,1,0, 0,5,0,  0,0,0,2});
      tbl.push_back('{0,1,0, 3,5,0,  0,0,0,2});
      // zero-length burst
      tbl.push_back('{0,1,0, 2,5,0,  0,0,1,0});
      tbl.push_back('{0,0,0, 2,5,0,  0,0,0,0});

      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].s, tbl[i].sp,
              tbl[i].md, tbl[i].dv, tbl[i].bl);
         chk("tbl_trig", trig0, tbl[i].et);
         chk("tbl_busy", busy0, tbl[i].eb);
         chk("tbl_done", done0, tbl[i].ed);
         chk("tbl_cnt", cnt0, tbl[i].ec);
      end

      // continuous div 10; divider input moves to 4 mid-run
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 10, 0);
      chk("c10_first", trig0, 1);
      for (int c = 2; c <= 45; c++) begin
         step(0, 0, 0, 1, (c > 20) ? 4 : 10, 0);
         chk("c10_trig", trig0, ((c - 1) % 10) == 0);
         if (c == 41) chk("c10_cnt41", cnt0, 5);
      end
      step(0, 0, 1, 1, 4, 0);
      chk("stop_trig", trig0, 0);
      chk("stop_busy", busy0, 0);
      chk("stop_done", done0, 0);

      // PULSE_LEN 5 with divider 3: high 2, low 1
      step(0, 1, 0, 1, 3, 0);
      for (int c = 1; c <= 9; c++) begin
         if (c > 1) step(0, 0, 0, 1, 3, 0);
         chk("pl5_trig", trig1, ((c - 1) % 3) < 2);
      end
      step(0, 0, 1, 1, 3, 0);

      // reset in the middle of a burst
      step(0, 1, 0, 2, 4, 3);
      for (int c = 0; c < 5; c++) step(0, 0, 0, 2, 4, 3);
      step(1, 1, 1, 2, 4, 3);
      chk("rst_trig", trig0, 0); chk("rst_busy", busy0, 0);
      chk("rst_done", done0, 0); chk("rst_cnt", cnt0, 0);
      step(0, 0, 0, 0, 0, 0);

      // random stimulus against the model
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 299) == 0,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 39) == 0,
              int'($urandom_range(0, 3)),
              longint'($urandom_range(0, 12)),
              longint'($urandom_range(0, 4)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_trigger_seq.md
ADC_TRIGGER_SEQ -- requirements
Module: adc_trigger_seq

Interface
REQ-001 Parameter DIV_WIDTH, default 32, SHALL set the width of the divider input.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of burst_len and trig_count.
REQ-003 Parameter PULSE_LEN, default 1, SHALL set the nominal trigger high time in clk cycles (range 1 to 255).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 The ports SHALL be as follows, listed as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- divider  in  DIV_WIDTH  trigger period in clk cycles.
- mode  in  2  0 = off, 1 = continuous, 2 = burst, 3 = reserved (treated as off).
- burst_len  in  CNT_WIDTH  number of triggers in burst mode.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle abort request.
- trigger  out  1  registered ADC conversion trigger.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse when a burst completes.
- trig_count  out  CNT_WIDTH  triggers issued since the last start.

Function
REQ-006 The FSM SHALL have two states: IDLE and RUN.
REQ-007 In IDLE, start with stop low and mode 1 or 2 SHALL latch divider, mode and burst_len, clear trig_count, and enter RUN.
- Latency: trigger rises on the first cycle after start is sampled.
REQ-008 The effective period P SHALL be max(divider, 2).
- The phase counter SHALL run 0..P-1 and wrap.
- trigger SHALL be high while phase < min(PULSE_LEN, P-1).
REQ-009 trig_count SHALL increment by 1 on every trigger rising edge.
- trig_count SHALL wrap modulo 2^CNT_WIDTH in continuous mode.
REQ-010 Burst: after burst_len triggers have been issued, the FSM SHALL return to IDLE at the end of the last period and pulse done for exactly one cycle.
REQ-011 Burst with burst_len = 0 SHALL issue no trigger, pulse done one cycle after start, and return to IDLE.
REQ-012 Continuous mode SHALL run until stop or reset.
REQ-013 stop in RUN SHALL force IDLE on the next cycle with trigger and busy low; done SHALL not pulse.
REQ-014 start while in RUN SHALL be ignored.
- If start and stop are sampled in the same IDLE cycle, stop SHALL win and start is ignored.
REQ-015 Start with mode 0 or 3 SHALL be ignored.
REQ-016 Changes to divider, mode or burst_len during RUN SHALL have no effect until the next start.
REQ-017 trig_count SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-018 While reset is high on a clk edge, the block SHALL:
- enter IDLE;
- drive trigger = 0, busy = 0, done = 0, trig_count = 0;
- clear the phase counter and all latched configuration.
REQ-019 Reset mid-RUN SHALL abort immediately with no done pulse.
- Reset SHALL take priority over start and stop.

Configuration
REQ-020 With macro ADC_TRIGGER_EXT_SYNC_EN defined, the block SHALL add an input ext_sync (1 bit, asynchronous).
- ext_sync SHALL pass through a 2-flop synchronizer and rising-edge detect.
- The detected edge SHALL be ORed with start, adding 3 cycles of latency to the first trigger.
REQ-021 Without ADC_TRIGGER_EXT_SYNC_EN, the ext_sync port and its logic SHALL be absent and behaviour SHALL be exactly as in REQ-006 to REQ-019.

Structure
REQ-022 Package adc_trigger_pkg SHALL hold:
- the mode enum (OFF, CONT, BURST, RSVD);
- the FSM state enum (IDLE, RUN);
- the constant MIN_PERIOD = 2.
REQ-023 Sub-module adc_trigger_sync SHALL implement the synchronizer and edge detect.
- It SHALL be instantiated only under ADC_TRIGGER_EXT_SYNC_EN.

Verification
REQ-024 Continuous, divider = 10, PULSE_LEN = 1, start at cycle 0:
- trigger is high at cycles 1, 11, 21, ...;
- trig_count = 5 after cycle 41.
REQ-025 Burst, divider = 4, burst_len = 3:
- exactly 3 triggers;
- done pulses once at cycle 12 after start;
- busy falls with done; trig_count = 3 is held.
REQ-026 Edge cases:
- divider = 0 gives period 2, trigger toggling 1,0,1,0;
- burst_len = 0 gives done one cycle after start with no trigger;
- PULSE_LEN = 5 with divider = 3 gives trigger high 2 cycles, low 1 cycle.
REQ-027 Stop and start handling:
- stop at cycle 7 of a continuous run gives trigger low and busy low from cycle 8, no done;
- start and stop in the same IDLE cycle leaves the FSM in IDLE.
REQ-028 Reset and reconfiguration:
- reset asserted mid-burst returns all outputs to 0 the next cycle;
- changing divider from 10 to 4 during RUN keeps a period of 10 until the next start.
REQ-029 With ADC_TRIGGER_EXT_SYNC_EN, a single ext_sync rising edge SHALL produce the first trigger 4 cycles after the edge is sampled.
